// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter that shares one 64-bit right shifter
// (logical/arithmetic, 0..63) among N_REQ requesters, each with its own
// valid/ready request and response channels.
// Optional feature: define SHIFT_ARB_BYPASS_EN so that a shift of 0 skips
// the EXEC cycle and its result is valid one cycle after acceptance.
module shift_arb #(
    parameter int N_REQ = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ-1:0]      req_arith_i,
    input  logic [6*N_REQ-1:0]    req_shift_i,
    input  logic [64*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output logic [63:0]           rsp_data_o,
    output logic                  busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic               arith_q, arith_d;
    logic [5:0]         shift_q, shift_d;
    logic [63:0]        data_q, data_d;
    logic [63:0]        rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [N_REQ-1:0]   win_oh;
    logic [5:0]         sel_shift;
    logic [63:0]        sel_data;
    logic               sel_arith;
    logic [63:0]        asr_res;
    logic [63:0]        shift_res;

    // Wrap an index in [0, 2*N_REQ) back into [0, N_REQ).
    function automatic logic [IDX_W-1:0] wrap_idx(input int a);
        int r;
        r = (a >= N_REQ) ? a - N_REQ : a;
        return IDX_W'(r);
    endfunction

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid_i[wrap_idx(int'(ptr_q) + i)]) begin
                found = 1'b1;
                win   = wrap_idx(int'(ptr_q) + i);
            end
        end
        win_oh       = '0;
        win_oh[win]  = 1'b1;
        sel_shift    = req_shift_i[int'(win)*6 +: 6];
        sel_data     = req_data_i[int'(win)*64 +: 64];
        sel_arith    = req_arith_i[win];
    end

    // Signed shift kept in its own assignment so the operand stays signed.
    assign asr_res = $signed(data_q) >>> shift_q;

    // The shared shifter: sign-fill or zero-fill.
    always_comb begin
        shift_res = arith_q ? asr_res : (data_q >> shift_q);
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        arith_d     = arith_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_o = win_oh;
                    arith_d     = sel_arith;
                    shift_d     = sel_shift;
                    data_d      = sel_data;
                    g_d         = win;
                    ptr_d       = wrap_idx(int'(win) + 1);
                    state_d     = EXEC;
`ifdef SHIFT_ARB_BYPASS_EN
                    // Zero shift is the identity: publish the operand now.
                    if (sel_shift == 6'd0) begin
                        rsp_data_d  = sel_data;
                        rsp_valid_d = win_oh;
                        state_d     = RESP;
                    end
`else
`endif
                end
            end
            EXEC: begin
                rsp_data_d       = shift_res;
                rsp_valid_d      = '0;
                rsp_valid_d[g_q] = 1'b1;
                state_d          = RESP;
            end
            RESP: begin
                // Only the granted requester's ready can retire the result.
                if (rsp_ready_i[g_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            arith_q     <= 1'b0;
            shift_q     <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            arith_q     <= arith_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: directed and random stimulus for shift_arb, checked against a
// transaction-level model (grant order by rotating search, result by bitwise
// definition, response time by acceptance timestamp).
module tb_shift_arb;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, req_arith;
    logic [6*N-1:0]    req_shift;
    logic [64*N-1:0]   req_data;
    logic [N-1:0]      rsp_valid, rsp_ready;
    logic [63:0]       rsp_data;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    // model state
    bit          m_act;
    int          m_own, m_ptr, m_due, cyc;
    logic [63:0] m_res, m_last;

    shift_arb #(.N_REQ(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_arith_i(req_arith), .req_shift_i(req_shift), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    // Result bit i is operand bit i+sh, or the fill bit past the top.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh, input bit ar);
        logic [63:0] r;
        for (int i = 0; i < 64; i++)
            r[i] = (i + sh < 64) ? d[i + sh] : (ar ? d[63] : 1'b0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: compare all outputs against the model, then advance it.
    task automatic step();
        bit vis;
        int w, sh, lat;
        @(negedge clk);
        vis = m_act && (cyc >= m_due);
        w   = pick(m_ptr, req_valid);
        chk("req_ready", {60'd0, req_ready}, {60'd0, (m_act ? '0 : onehot(w))});
        chk("rsp_valid", {60'd0, rsp_valid}, {60'd0, (vis ? onehot(m_own) : '0)});
        chk("rsp_data", rsp_data, vis ? m_res : m_last);
        chk("busy", {63'd0, busy}, {63'd0, m_act});
        if (rst) begin
            m_act = 0; m_ptr = 0; m_last = '0;
        end else if (!m_act) begin
            if (w >= 0) begin
                sh    = int'(req_shift[w*6 +: 6]);
                lat   = 2;
`ifdef SHIFT_ARB_BYPASS_EN
                if (sh == 0) lat = 1;
`endif
                m_act = 1;
                m_own = w;
                m_ptr = (w + 1) % N;
                m_res = ref_shift(req_data[w*64 +: 64], sh, req_arith[w]);
                m_due = cyc + lat;
            end
        end else if (vis && rsp_ready[m_own]) begin
            m_act  = 0;
            m_last = m_res;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [63:0] d, input int sh, input bit ar);
        req_valid[k]         = 1'b1;
        req_data[k*64 +: 64] = d;
        req_shift[k*6 +: 6]  = 6'(sh);
        req_arith[k]         = ar;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_arith = '0; req_shift = '0;
        req_data = '0; rsp_ready = '0;
        m_act = 0; m_ptr = 0; m_last = '0; m_res = '0; m_own = 0; m_due = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        step();                      // reset state with rst still high
        rst = 1'b0;
        idle(1);

        // single arithmetic op from requester 0
        rsp_ready = '1;
        set_req(0, 64'h8000_0000_0000_00F0, 4, 1'b1);
        step();
        req_valid = '0;
        step();
        chk("single_vld", {60'd0, rsp_valid}, 64'h1);
        chk("single_data", rsp_data, 64'hF800_0000_0000_000F);
        idle(3);

        // full-width shift, logical then arithmetic fill
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b0);
        step(); req_valid = '0; step();
        chk("lsr63_vld", {60'd0, rsp_valid}, 64'h4);
        chk("lsr63_data", rsp_data, 64'h1);
        idle(3);
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b1);
        step(); req_valid = '0; step();
        chk("asr63_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(3);

        // round-robin with every requester asserting continuously
        for (int k = 0; k < N; k++) set_req(k, 64'h1234_5678_9ABC_DEF0 + 64'(k), 1, k[0]);
        rsp_ready = '1;
        for (int i = 0; i < 16; i++) step();
        idle(4);

        // back-pressure on requester 1 while requester 3 waits
        set_req(1, 64'hF0F0_0000_1111_2222, 8, 1'b1);
        set_req(3, 64'h0000_0000_0000_FF00, 8, 1'b0);
        rsp_ready = '0;
        for (int i = 0; i < 8; i++) step();
        rsp_ready = '1;
        for (int i = 0; i < 8; i++) step();
        idle(4);

        // reset during EXEC, then pointer back at requester 0
        set_req(2, 64'h5555_AAAA_5555_AAAA, 3, 1'b0);
        step();
        rst = 1'b1;
        set_req(0, 64'h7, 1, 1'b0);
        step();
        rst = 1'b0;
        chk("rst_ready", {60'd0, req_ready}, 64'h1);
        chk("rst_vld", {60'd0, rsp_valid}, 64'h0);
        step();
        idle(4);

        // zero shift: identity result, latency depends on bypass build
        set_req(0, 64'h1234, 0, 1'b1);
        step(); req_valid = '0;
`ifdef SHIFT_ARB_BYPASS_EN
        chk("zero_vld_t1", {60'd0, rsp_valid}, 64'h1);
`else
        chk("zero_vld_t1", {60'd0, rsp_valid}, 64'h0);
`endif
        step();
        chk("zero_data", rsp_data, 64'h1234);
        idle(3);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < N; k++) begin
                int sh;
                sh = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 63)
                                                 : int'($urandom_range(0, 63));
                req_valid[k]         = ($urandom_range(0, 2) != 0);
                req_data[k*64 +: 64] = {$urandom, $urandom};
                req_shift[k*6 +: 6]  = 6'(sh);
                req_arith[k]         = 1'($urandom_range(0, 1));
                rsp_ready[k]         = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
